// File: rtl/divclk_mon_pkg.sv
// Shared types for the divided-clock monitor: FSM state encoding and counter widths.
package divclk_mon_pkg;

  localparam int unsigned STATE_W = 3;
  localparam int unsigned GOOD_W  = 4;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE    = 3'd0,
    ST_FIRST   = 3'd1,
    ST_ACQUIRE = 3'd2,
    ST_LOCKED  = 3'd3,
    ST_FAULT   = 3'd4
  } state_e;

endpackage

// File: rtl/divclk_edge_sync.sv
// Brings div_clk into the clk_in domain and produces registered rise/fall ticks.
// DIVCLK_MON_SYNC_EN selects a 2-flop synchroniser; otherwise div_clk is used directly.
module divclk_edge_sync (
  input  logic clk_in,
  input  logic reset,
  input  logic div_clk_i,
  input  logic tick_en_i,
  output logic edge_o,
  output logic rise_tick_o,
  output logic fall_tick_o
);

  logic s_w;
  logic d_q;
  logic rise_q, rise_d;
  logic fall_q, fall_d;

`ifdef DIVCLK_MON_SYNC_EN
  logic [1:0] sync_q;

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) sync_q <= '0;
    else       sync_q <= {sync_q[0], div_clk_i};
  end

  assign s_w = sync_q[1];
`else
  assign s_w = div_clk_i;
`endif

  // d_q follows s_w even while ticks are suppressed, so enabling never sees a stale edge
  assign edge_o = (s_w != d_q);
  assign rise_d = tick_en_i && edge_o && s_w;
  assign fall_d = tick_en_i && edge_o && !s_w;

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      d_q    <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      d_q    <= s_w;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign rise_tick_o = rise_q;
  assign fall_tick_o = fall_q;

endmodule

// File: rtl/divclk_monitor.sv
// Divided-clock monitor: half-period measurement and lock/fault FSM.
// Optional synchroniser on div_clk enabled by DIVCLK_MON_SYNC_EN (see divclk_edge_sync).
module divclk_monitor
  import divclk_mon_pkg::*;
#(
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned LOCK_CNT = 4,
  parameter int unsigned TOL      = 0
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             div_clk,
  input  logic             en,
  input  logic [CNT_W-1:0] exp_half,
  output logic             rise_tick,
  output logic             fall_tick,
  output logic             meas_valid,
  output logic [CNT_W-1:0] half_cnt,
  output logic             locked,
  output logic             fault
);

  localparam logic [CNT_W:0]    TOL_X  = (CNT_W+1)'(TOL);
  localparam logic [CNT_W:0]    ONE_X  = (CNT_W+1)'(1);
  localparam logic [GOOD_W-1:0] LOCK_N = GOOD_W'(LOCK_CNT);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   half_q, half_d;
  logic               mv_q, mv_d;
  logic [GOOD_W-1:0]  good_q, good_d;

  logic               edge_w;
  logic               tick_en;
  logic [CNT_W:0]     meas_x, exp_x, dev_x;
  logic               good_meas;
  logic               timeout;

  assign tick_en = en && (state_q != ST_IDLE);

  divclk_edge_sync u_edge (
    .clk_in      (clk_in),
    .reset       (reset),
    .div_clk_i   (div_clk),
    .tick_en_i   (tick_en),
    .edge_o      (edge_w),
    .rise_tick_o (rise_tick),
    .fall_tick_o (fall_tick)
  );

  // Compare one bit wider than the counter so neither subtraction nor limit can wrap
  assign meas_x    = {1'b0, cnt_q};
  assign exp_x     = {1'b0, exp_half};
  assign dev_x     = (meas_x >= exp_x) ? (meas_x - exp_x) : (exp_x - meas_x);
  assign good_meas = (dev_x <= TOL_X);
  assign timeout   = !edge_w && (meas_x >= exp_x + TOL_X + ONE_X);

  assign cnt_d = edge_w ? CNT_W'(1) : ((cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1));

  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    mv_d    = 1'b0;
    half_d  = half_q;
    if (!en) begin
      state_d = ST_IDLE;
      good_d  = '0;
    end else begin
      unique case (state_q)
        ST_IDLE:    state_d = (exp_half == '0) ? ST_FAULT : ST_FIRST;
        ST_FIRST:   if (edge_w) state_d = ST_ACQUIRE;
        ST_ACQUIRE: begin
          if (edge_w) begin
            mv_d   = 1'b1;
            half_d = cnt_q;
            if (good_meas) begin
              good_d = good_q + GOOD_W'(1);
              if (good_d == LOCK_N) state_d = ST_LOCKED;
            end else begin
              good_d = '0;
            end
          end else if (timeout) begin
            good_d  = '0;
            state_d = ST_FIRST;
          end
        end
        ST_LOCKED: begin
          if (edge_w) begin
            mv_d   = 1'b1;
            half_d = cnt_q;
            if (!good_meas) state_d = ST_FAULT;
          end else if (timeout) begin
            state_d = ST_FAULT;
          end
        end
        ST_FAULT: begin
          if (edge_w) begin
            mv_d   = 1'b1;
            half_d = cnt_q;
          end
        end
        default:    state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      good_q  <= '0;
      mv_q    <= 1'b0;
      half_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      good_q  <= good_d;
      mv_q    <= mv_d;
      half_q  <= half_d;
    end
  end

  assign meas_valid = mv_q;
  assign half_cnt   = half_q;
  assign locked     = (state_q == ST_LOCKED);
  assign fault      = (state_q == ST_FAULT);

endmodule
